// File: rtl/q2_demux1to4_reg_if.sv
// Bus bundle for the registered 1-to-4 demux: source handshake, select/mode,
// consumer ack, and the four channel outputs with their status.
interface q2_demux1to4_reg_if #(
   parameter int unsigned DATA_W  = 1,
   parameter int unsigned STALL_W = 8
);
   logic [DATA_W-1:0]  din;
   logic               din_valid;
   logic               din_ready;
   logic [1:0]         s;
   logic               auto_mode;
   logic [3:0]         ack;
   logic [DATA_W-1:0]  a;
   logic [DATA_W-1:0]  b;
   logic [DATA_W-1:0]  c;
   logic [DATA_W-1:0]  d;
   logic [3:0]         full;
   logic [1:0]         ptr;
   logic [STALL_W-1:0] stall_cnt;

   modport master (
      output din, din_valid, s, auto_mode, ack,
      input  din_ready, a, b, c, d, full, ptr, stall_cnt
   );

   modport slave (
      input  din, din_valid, s, auto_mode, ack,
      output din_ready, a, b, c, d, full, ptr, stall_cnt
   );
endinterface

// File: rtl/q2_demux1to4_reg.sv
// Registered 1-to-4 demultiplexer with per-channel occupancy, consumer ack,
// manual or round-robin target selection and a saturating stall counter.
module q2_demux1to4_reg #(
   parameter int unsigned DATA_W  = 1,
   parameter int unsigned STALL_W = 8
) (
   input logic                clk,
   input logic                rst,
   q2_demux1to4_reg_if.slave  bus
);

   logic [DATA_W-1:0]  data_q [4];
   logic [DATA_W-1:0]  data_d [4];
   logic [3:0]         full_q, full_d;
   logic [1:0]         ptr_q, ptr_d;
   logic [STALL_W-1:0] stall_q, stall_d;
   logic [1:0]         tgt;
   logic               ready;
   logic               xfer;

   assign tgt   = bus.auto_mode ? ptr_q : bus.s;
   // An ack on the target frees it this cycle, so a full channel can stream without a bubble.
   assign ready = ~full_q[tgt] | bus.ack[tgt];
   assign xfer  = bus.din_valid & ready;

   always_comb begin
      data_d  = data_q;
      full_d  = full_q & ~bus.ack;
      ptr_d   = ptr_q;
      stall_d = stall_q;
      if (xfer) begin
         data_d[tgt] = bus.din;
         full_d[tgt] = 1'b1;
         if (bus.auto_mode) begin
            ptr_d = ptr_q + 2'd1;
         end
      end
      if (bus.din_valid && !ready && (stall_q != {STALL_W{1'b1}})) begin
         stall_d = stall_q + {{(STALL_W-1){1'b0}}, 1'b1};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         data_q  <= '{default: '0};
         full_q  <= '0;
         ptr_q   <= '0;
         stall_q <= '0;
      end else begin
         data_q  <= data_d;
         full_q  <= full_d;
         ptr_q   <= ptr_d;
         stall_q <= stall_d;
      end
   end

   assign bus.din_ready = ready;
   assign bus.a         = data_q[0];
   assign bus.b         = data_q[1];
   assign bus.c         = data_q[2];
   assign bus.d         = data_q[3];
   assign bus.full      = full_q;
   assign bus.ptr       = ptr_q;
   assign bus.stall_cnt = stall_q;

endmodule
